ct_ct_addsub: RTL and testbench
===============================

Name: ct_ct_addsub

Overview:
- Parametrised successor to the two-component ciphertext adder. Computes element-wise modular addition or subtraction of two ciphertexts of NUM_COMP polynomial components, each N coefficients of K bits, modulo Q.
- All components are processed in lockstep from one shared coefficient counter. Streams operands from two read ports and writes results to one write port.
- Sits in cloud_ops beside the other homomorphic operators and is driven by the cloud-side controller with a level start/done handshake.

Parameters:
- N, `N, coefficients per polynomial; power of two, >= 2.
- K, `K, coefficient width in bits.
- Q, 2**K-1, modulus; 2 <= Q < 2**K.
- NUM_COMP, 2, ciphertext components processed in parallel; >= 1.
- RD_LAT, 1, read latency of the operand memories in cycles; >= 1.

Ports:
- clk  in  1  clock.
- reset  in  1  asynchronous, active-high reset.
- start  in  1  level request; sampled in IDLE.
- op_sub  in  1  0 = add, 1 = subtract (A-B); latched when start is accepted.
- rd_en  out  1  operand read enable, shared by A and B.
- rd_addr  out  $clog2(N)  coefficient index, shared by all components.
- a_rd_data  in  NUM_COMP*K  operand A; component c is at [c*K +: K].
- b_rd_data  in  NUM_COMP*K  operand B; same packing.
- wr_en  out  1  result write enable.
- wr_addr  out  $clog2(N)  result coefficient index.
- wr_data  out  NUM_COMP*K  results; same packing.
- busy  out  1  high in RUN and DRAIN.
- done  out  1  completion flag; held until start is deasserted.

Behaviour:
- Reset (asynchronous): state goes to IDLE. rd_en, rd_addr, wr_en, wr_addr, wr_data, busy and done are all 0. Latched op is 0, and all pipeline valid bits are cleared.
- Reset mid-operation: takes effect immediately. No further writes occur and no done is produced. A new start is required afterwards.
- States: IDLE, RUN, DRAIN, DONE.
  - IDLE -> RUN on a clock edge with start=1; op_sub is latched on that edge.
  - RUN -> DRAIN after issuing address N-1.
  - DRAIN -> DONE after the last write.
  - DONE -> IDLE when start=0.
- Timing: cycle 0 is the first cycle in RUN.
  - Cycle i (0..N-1): rd_en=1, rd_addr=i.
  - a_rd_data/b_rd_data for index i are valid at cycle i+RD_LAT. They are registered through one compute stage.
  - Cycle i+RD_LAT+1: wr_en=1, wr_addr=i, wr_data=f(A[i],B[i]).
  - Exactly N writes, one per cycle, in ascending address order, with no gaps.
  - Last write at cycle N+RD_LAT. done rises at cycle N+RD_LAT+1; busy falls on the same cycle.
  - Total start-accept-to-done latency is N+RD_LAT+2 edges.
- Outside valid cycles, rd_en=0 and wr_en=0. rd_addr, wr_addr and wr_data hold their last value.
- Per-component arithmetic, in K+1 bits:
  - Add: s = a + b; result = s - Q if s >= Q, else s.
  - Sub: d = a - b; result = d + Q if a < b, else d.
  - Result is truncated to K bits. Correctness is guaranteed only for a, b < Q; out-of-range inputs follow the same formula without a check.
- Components are independent; no carries cross component boundaries.
- start while busy or in DONE is ignored. op_sub changes after acceptance have no effect.
- start held high through DONE keeps done=1. A new operation requires start low for at least one cycle, which returns the block to IDLE.
- The counter reaching N-1 terminates RUN; it never wraps to 0 within an operation.
- NUM_COMP=1 and RD_LAT>1 must work with no RTL edits.
- Memories are external. Any write/read address collision between the result memory and the operand memories (in-place operation) is the integrator's responsibility. The block itself imposes no ordering beyond the above.

Test Plan:
- Bench configuration: N=8, K=8, Q=251, NUM_COMP=2, RD_LAT=1 unless stated otherwise.
- Add, no wrap: A0[i]=i, B0[i]=10, A1[i]=100, B1[i]=i -> wr_data comp0 = i+10, comp1 = 100+i. Writes occur at cycles 2..9; done rises at cycle 10.
- Add with wrap and boundary: A=250, B=250 -> 249. A=250, B=1 -> 0. A=0, B=0 -> 0.
- Sub: A=5, B=10 -> 246. A=10, B=5 -> 5. A=0, B=250 -> 1. A=B -> 0. op_sub toggled mid-run must not change any result.
- RD_LAT=3, NUM_COMP=3: writes at cycles 4..11 in address order 0..7; done rises at cycle 12. Each component's result matches the reference model.
- Handshake: hold start high -> done stays 1 for 20 cycles and no second run occurs. Drop start -> done=0 next cycle, state IDLE. Re-raise start -> second full run with 8 writes.
- Reset asserted at cycle 5 of RUN -> all outputs 0 immediately, no subsequent wr_en. After release, a new start completes normally.

Source files
------------

// File: rtl/ct_ct_addsub.sv
// ct_ct_addsub: element-wise modular add/subtract of two ciphertexts.
// NUM_COMP polynomial components are processed in lockstep from one shared
// coefficient counter. Operands stream in from two read ports with RD_LAT
// cycles of latency, pass through one compute register, and leave through a
// single write port. A level start/done handshake drives the block.
module ct_ct_addsub #(
  parameter int N        = 8,
  parameter int K        = 8,
  parameter int Q        = (2 ** K) - 1,
  parameter int NUM_COMP = 2,
  parameter int RD_LAT   = 1
) (
  input  logic                    clk,
  input  logic                    reset,
  input  logic                    start,
  input  logic                    op_sub,
  output logic                    rd_en,
  output logic [$clog2(N)-1:0]    rd_addr,
  input  logic [NUM_COMP*K-1:0]   a_rd_data,
  input  logic [NUM_COMP*K-1:0]   b_rd_data,
  output logic                    wr_en,
  output logic [$clog2(N)-1:0]    wr_addr,
  output logic [NUM_COMP*K-1:0]   wr_data,
  output logic                    busy,
  output logic                    done
);

  localparam int AW = $clog2(N);
  localparam logic [AW-1:0] LAST_ADDR = AW'(N - 1);
  // The modulus is kept one bit wider than a coefficient so the raw sum and
  // the borrowed difference can be corrected without losing the carry bit.
  localparam logic [K:0] Q_EXT = (K + 1)'(Q);

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_RUN   = 2'd1,
    S_DRAIN = 2'd2,
    S_DONE  = 2'd3
  } state_e;

  state_e                  state_q, state_d;
  logic                    rd_en_q, rd_en_d;
  logic [AW-1:0]           rd_addr_q, rd_addr_d;
  logic                    op_q, op_d;
  logic                    busy_q, busy_d;
  logic                    done_q, done_d;

  // Read-side valid and address travel together for RD_LAT cycles so that
  // each returning operand word is paired with the index it was read from.
  logic [RD_LAT-1:0]       vld_q;
  logic [AW-1:0]           addr_pipe_q [RD_LAT];

  logic                    wr_en_q;
  logic [AW-1:0]           wr_addr_q;
  logic [NUM_COMP*K-1:0]   wr_data_q;
  logic [NUM_COMP*K-1:0]   res_s;

  // Modular add or subtract of one coefficient pair, computed in K+1 bits.
  // Inputs are assumed already reduced below Q; nothing checks that.
  function automatic logic [K-1:0] mod_addsub(
    input logic [K-1:0] a,
    input logic [K-1:0] b,
    input logic         sub
  );
    logic [K:0]   t;
    logic [K-1:0] r;
    if (sub) begin
      t = {1'b0, a} - {1'b0, b};
      if (a < b) begin
        r = K'(t + Q_EXT);
      end else begin
        r = K'(t);
      end
    end else begin
      t = {1'b0, a} + {1'b0, b};
      if (t >= Q_EXT) begin
        r = K'(t - Q_EXT);
      end else begin
        r = K'(t);
      end
    end
    return r;
  endfunction

  // Next-state logic for the sequencing FSM and the read-side outputs.
  always_comb begin
    state_d   = state_q;
    rd_en_d   = 1'b0;
    rd_addr_d = rd_addr_q;
    op_d      = op_q;
    case (state_q)
      S_IDLE: begin
        if (start) begin
          state_d   = S_RUN;
          rd_en_d   = 1'b1;
          rd_addr_d = '0;
          op_d      = op_sub;
        end else begin
          state_d = S_IDLE;
        end
      end
      S_RUN: begin
        // The final index ends the read phase; the counter never wraps.
        if (rd_addr_q == LAST_ADDR) begin
          state_d = S_DRAIN;
        end else begin
          rd_en_d   = 1'b1;
          rd_addr_d = rd_addr_q + AW'(1);
        end
      end
      S_DRAIN: begin
        // Writes come out in ascending order, so the write of the last index
        // is the last write of the operation.
        if (wr_en_q && (wr_addr_q == LAST_ADDR)) begin
          state_d = S_DONE;
        end else begin
          state_d = S_DRAIN;
        end
      end
      S_DONE: begin
        if (!start) begin
          state_d = S_IDLE;
        end else begin
          state_d = S_DONE;
        end
      end
      default: begin
        state_d = S_IDLE;
      end
    endcase
    busy_d = (state_d == S_RUN) || (state_d == S_DRAIN);
    done_d = (state_d == S_DONE);
  end

  // State register and registered control outputs.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q   <= S_IDLE;
      rd_en_q   <= 1'b0;
      rd_addr_q <= '0;
      op_q      <= 1'b0;
      busy_q    <= 1'b0;
      done_q    <= 1'b0;
    end else begin
      state_q   <= state_d;
      rd_en_q   <= rd_en_d;
      rd_addr_q <= rd_addr_d;
      op_q      <= op_d;
      busy_q    <= busy_d;
      done_q    <= done_d;
    end
  end

  // Per-component arithmetic; components share nothing, so no carry crosses
  // a K-bit boundary.
  always_comb begin
    res_s = '0;
    for (int c = 0; c < NUM_COMP; c++) begin
      res_s[c*K +: K] = mod_addsub(a_rd_data[c*K +: K], b_rd_data[c*K +: K], op_q);
    end
  end

  // Read-latency alignment pipeline and the single compute/write register.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      vld_q     <= '0;
      for (int j = 0; j < RD_LAT; j++) begin
        addr_pipe_q[j] <= '0;
      end
      wr_en_q   <= 1'b0;
      wr_addr_q <= '0;
      wr_data_q <= '0;
    end else begin
      vld_q[0]       <= rd_en_q;
      addr_pipe_q[0] <= rd_addr_q;
      for (int j = 1; j < RD_LAT; j++) begin
        vld_q[j]       <= vld_q[j-1];
        addr_pipe_q[j] <= addr_pipe_q[j-1];
      end
      wr_en_q <= vld_q[RD_LAT-1];
      // Address and data hold their last value between operations.
      if (vld_q[RD_LAT-1]) begin
        wr_addr_q <= addr_pipe_q[RD_LAT-1];
        wr_data_q <= res_s;
      end
    end
  end

  assign rd_en   = rd_en_q;
  assign rd_addr = rd_addr_q;
  assign wr_en   = wr_en_q;
  assign wr_addr = wr_addr_q;
  assign wr_data = wr_data_q;
  assign busy    = busy_q;
  assign done    = done_q;

endmodule

// File: tb/tb_ct_ct_addsub.sv
// Directed bench for ct_ct_addsub: one instance with N=8, K=8, Q=251,
// NUM_COMP=2, RD_LAT=1 and a second with NUM_COMP=3, RD_LAT=3.
module tb_ct_ct_addsub;

  localparam int N = 8;
  localparam int Q = 251;

  logic        clk = 1'b0;
  logic        reset;

  logic        start1, op1, rd_en1, wr_en1, busy1, done1;
  logic [2:0]  rd_addr1, wr_addr1;
  logic [15:0] a_d1, b_d1, wr_data1;

  logic        start2, op2, rd_en2, wr_en2, busy2, done2;
  logic [2:0]  rd_addr2, wr_addr2;
  logic [23:0] a_d2, b_d2, wr_data2;

  logic [15:0] a1 [N];
  logic [15:0] b1 [N];
  logic [15:0] e1 [N];
  logic [23:0] a2 [N];
  logic [23:0] b2 [N];
  logic [23:0] e2 [N];
  logic [23:0] a2p [3];
  logic [23:0] b2p [3];

  int errors = 0;
  int checks = 0;

  always #5 clk = ~clk;

  ct_ct_addsub #(.N(8), .K(8), .Q(251), .NUM_COMP(2), .RD_LAT(1)) u_dut1 (
    .clk(clk), .reset(reset), .start(start1), .op_sub(op1),
    .rd_en(rd_en1), .rd_addr(rd_addr1), .a_rd_data(a_d1), .b_rd_data(b_d1),
    .wr_en(wr_en1), .wr_addr(wr_addr1), .wr_data(wr_data1),
    .busy(busy1), .done(done1)
  );

  ct_ct_addsub #(.N(8), .K(8), .Q(251), .NUM_COMP(3), .RD_LAT(3)) u_dut2 (
    .clk(clk), .reset(reset), .start(start2), .op_sub(op2),
    .rd_en(rd_en2), .rd_addr(rd_addr2), .a_rd_data(a_d2), .b_rd_data(b_d2),
    .wr_en(wr_en2), .wr_addr(wr_addr2), .wr_data(wr_data2),
    .busy(busy2), .done(done2)
  );

  // Operand memory with one cycle of read latency.
  always @(posedge clk) begin
    a_d1 <= a1[rd_addr1];
    b_d1 <= b1[rd_addr1];
  end

  // Operand memory with three cycles of read latency.
  always @(posedge clk) begin
    a2p[0] <= a2[rd_addr2];
    b2p[0] <= b2[rd_addr2];
    a2p[1] <= a2p[0];
    b2p[1] <= b2p[0];
    a2p[2] <= a2p[1];
    b2p[2] <= b2p[1];
  end
  assign a_d2 = a2p[2];
  assign b_d2 = b2p[2];

  // Plain integer reference for one coefficient.
  function automatic int ref_mod(input int a, input int b, input bit sub);
    if (sub) return (a - b + Q) % Q;
    else     return (a + b) % Q;
  endfunction

  task automatic test_reset();
    checks++;
    if ({rd_en1, rd_addr1, wr_en1, wr_addr1, wr_data1, busy1, done1} !== '0) begin
      errors++;
      $display("FAIL reset_dut1 got=%h required=0",
               {rd_en1, rd_addr1, wr_en1, wr_addr1, wr_data1, busy1, done1});
    end
    checks++;
    if ({rd_en2, rd_addr2, wr_en2, wr_addr2, wr_data2, busy2, done2} !== '0) begin
      errors++;
      $display("FAIL reset_dut2 got=%h required=0",
               {rd_en2, rd_addr2, wr_en2, wr_addr2, wr_data2, busy2, done2});
    end
  endtask

  // Full operation on dut1 from acceptance to done; entered just after a negedge.
  task automatic run1(input bit toggle);
    int wcnt;
    logic [3:0] exp_ctrl;
    wcnt = 0;
    start1 = 1'b1;
    @(posedge clk);
    for (int cyc = 0; cyc <= N + 2; cyc++) begin
      @(negedge clk);
      exp_ctrl = {(cyc < N), (cyc >= 2 && cyc <= N + 1), (cyc <= N + 1), (cyc == N + 2)};
      checks++;
      if ({rd_en1, wr_en1, busy1, done1} !== exp_ctrl) begin
        errors++;
        $display("FAIL run1_ctrl cyc=%0d got=%b required=%b", cyc,
                 {rd_en1, wr_en1, busy1, done1}, exp_ctrl);
      end
      if (cyc < N) begin
        checks++;
        if (rd_addr1 !== 3'(cyc)) begin
          errors++;
          $display("FAIL run1_rd_addr cyc=%0d got=%0d required=%0d", cyc, rd_addr1, cyc);
        end
      end
      if (wr_en1 === 1'b1) wcnt++;
      if (cyc >= 2 && cyc <= N + 1) begin
        checks++;
        if ({wr_addr1, wr_data1} !== {3'(cyc - 2), e1[cyc - 2]}) begin
          errors++;
          $display("FAIL run1_write cyc=%0d got addr=%0d data=%h required addr=%0d data=%h",
                   cyc, wr_addr1, wr_data1, cyc - 2, e1[cyc - 2]);
        end
      end
      if (toggle) op1 = ~op1;
    end
    checks++;
    if (wcnt != N) begin
      errors++;
      $display("FAIL run1_wcount got=%0d required=%0d", wcnt, N);
    end
  endtask

  // Full operation on dut2 (RD_LAT=3): writes at cycles 4..11, done at 12.
  task automatic run2();
    int wcnt;
    logic [3:0] exp_ctrl;
    wcnt = 0;
    start2 = 1'b1;
    @(posedge clk);
    for (int cyc = 0; cyc <= N + 4; cyc++) begin
      @(negedge clk);
      exp_ctrl = {(cyc < N), (cyc >= 4 && cyc <= N + 3), (cyc <= N + 3), (cyc == N + 4)};
      checks++;
      if ({rd_en2, wr_en2, busy2, done2} !== exp_ctrl) begin
        errors++;
        $display("FAIL run2_ctrl cyc=%0d got=%b required=%b", cyc,
                 {rd_en2, wr_en2, busy2, done2}, exp_ctrl);
      end
      if (wr_en2 === 1'b1) wcnt++;
      if (cyc >= 4 && cyc <= N + 3) begin
        checks++;
        if ({wr_addr2, wr_data2} !== {3'(cyc - 4), e2[cyc - 4]}) begin
          errors++;
          $display("FAIL run2_write cyc=%0d got addr=%0d data=%h required addr=%0d data=%h",
                   cyc, wr_addr2, wr_data2, cyc - 4, e2[cyc - 4]);
        end
      end
    end
    checks++;
    if (wcnt != N) begin
      errors++;
      $display("FAIL run2_wcount got=%0d required=%0d", wcnt, N);
    end
  endtask

  // Release start on dut1 and confirm it returns to idle on the next edge.
  task automatic drop1();
    start1 = 1'b0;
    @(negedge clk);
    checks++;
    if ({done1, busy1, rd_en1, wr_en1} !== 4'b0000) begin
      errors++;
      $display("FAIL drop1_idle got=%b required=0000", {done1, busy1, rd_en1, wr_en1});
    end
  endtask

  task automatic test_add_nowrap();
    for (int i = 0; i < N; i++) begin
      a1[i] = {8'd100, 8'(i)};
      b1[i] = {8'(i), 8'd10};
      e1[i] = {8'(100 + i), 8'(i + 10)};
    end
    op1 = 1'b0;
    run1(1'b0);
    drop1();
  endtask

  task automatic test_add_wrap();
    logic [7:0] pa [N] = '{8'd250, 8'd250, 8'd0, 8'd1, 8'd2, 8'd125, 8'd125, 8'd200};
    logic [7:0] pb [N] = '{8'd250, 8'd1, 8'd0, 8'd249, 8'd249, 8'd126, 8'd125, 8'd100};
    logic [7:0] pe [N] = '{8'd249, 8'd0, 8'd0, 8'd250, 8'd0, 8'd0, 8'd250, 8'd49};
    for (int i = 0; i < N; i++) begin
      a1[i] = {8'(i), pa[i]};
      b1[i] = {8'd250, pb[i]};
      e1[i] = {((i == 0) ? 8'd250 : 8'(i - 1)), pe[i]};
    end
    op1 = 1'b0;
    run1(1'b0);
    drop1();
  endtask

  task automatic test_sub();
    logic [7:0] pa [N] = '{8'd5, 8'd10, 8'd0, 8'd7, 8'd250, 8'd0, 8'd250, 8'd100};
    logic [7:0] pb [N] = '{8'd10, 8'd5, 8'd250, 8'd7, 8'd0, 8'd1, 8'd250, 8'd37};
    logic [7:0] pe [N] = '{8'd246, 8'd5, 8'd1, 8'd0, 8'd250, 8'd250, 8'd0, 8'd63};
    for (int i = 0; i < N; i++) begin
      a1[i] = {8'd200, pa[i]};
      b1[i] = {8'(i), pb[i]};
      e1[i] = {8'(200 - i), pe[i]};
    end
    op1 = 1'b1;
    run1(1'b1);
    drop1();
  endtask

  task automatic test_rdlat3();
    for (int s = 0; s < 2; s++) begin
      for (int i = 0; i < N; i++) begin
        a2[i] = {8'(i), 8'(250 - i), 8'(30 * i)};
        b2[i] = {8'(250 - i), 8'(35 * i), 8'd40};
        e2[i] = {8'(ref_mod(i, 250 - i, s[0])),
                 8'(ref_mod(250 - i, 35 * i, s[0])),
                 8'(ref_mod(30 * i, 40, s[0]))};
      end
      op2 = s[0];
      run2();
      start2 = 1'b0;
      @(negedge clk);
      checks++;
      if ({done2, busy2} !== 2'b00) begin
        errors++;
        $display("FAIL drop2_idle got=%b required=00", {done2, busy2});
      end
    end
  endtask

  task automatic test_handshake();
    for (int i = 0; i < N; i++) begin
      a1[i] = {8'(3 * i), 8'(i)};
      b1[i] = {8'd1, 8'd2};
      e1[i] = {8'(3 * i + 1), 8'(i + 2)};
    end
    op1 = 1'b0;
    run1(1'b0);
    for (int k = 0; k < 20; k++) begin
      @(negedge clk);
      checks++;
      if ({done1, busy1, rd_en1, wr_en1, wr_addr1} !== {4'b1000, 3'd7}) begin
        errors++;
        $display("FAIL hold_done k=%0d got=%b required=1000111", k,
                 {done1, busy1, rd_en1, wr_en1, wr_addr1});
      end
    end
    drop1();
    run1(1'b0);
    drop1();
  endtask

  task automatic test_reset_mid();
    for (int i = 0; i < N; i++) begin
      a1[i] = {8'(i), 8'(i)};
      b1[i] = {8'd5, 8'd6};
      e1[i] = {8'(i + 5), 8'(i + 6)};
    end
    op1 = 1'b0;
    start1 = 1'b1;
    @(posedge clk);
    for (int cyc = 0; cyc < 5; cyc++) @(negedge clk);
    @(negedge clk);
    reset = 1'b1;
    start1 = 1'b0;
    #1;
    checks++;
    if ({rd_en1, rd_addr1, wr_en1, wr_addr1, wr_data1, busy1, done1} !== '0) begin
      errors++;
      $display("FAIL reset_mid_zero got=%h required=0",
               {rd_en1, rd_addr1, wr_en1, wr_addr1, wr_data1, busy1, done1});
    end
    @(negedge clk);
    @(negedge clk);
    reset = 1'b0;
    for (int k = 0; k < 12; k++) begin
      @(negedge clk);
      checks++;
      if ({wr_en1, rd_en1, busy1, done1} !== 4'b0000) begin
        errors++;
        $display("FAIL reset_mid_quiet k=%0d got=%b required=0000", k,
                 {wr_en1, rd_en1, busy1, done1});
      end
    end
    run1(1'b0);
    drop1();
  endtask

  initial begin
    reset  = 1'b1;
    start1 = 1'b0;
    op1    = 1'b0;
    start2 = 1'b0;
    op2    = 1'b0;
    @(negedge clk);
    test_reset();
    @(negedge clk);
    reset = 1'b0;
    @(negedge clk);
    test_add_nowrap();
    test_add_wrap();
    test_sub();
    test_rdlat3();
    test_handshake();
    test_reset_mid();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
